// File: rtl/dtc_edge_gen.sv
`timescale 1fs/1fs
// Behavioural DTC: each accepted signed code schedules one dtc_out edge (code+TDC_RANGE)*TDC_STEP fs after fbclk.
// Optional feature macro DTC_CLAMP_EN: clamp out-of-range codes to +/-TDC_RANGE instead of dropping them.
module dtc_edge_gen #(
    parameter longint TDC_STEP    = 1000,
    parameter longint TDC_RANGE   = 4000,
    parameter longint PULSE_WIDTH = 100000,
    parameter int     DEPTH       = 4
) (
    input  logic               fbclk,
    input  logic               resetn,
    input  logic signed [31:0] code,
    input  logic               code_valid,
    output logic               code_ready,
    output logic               dtc_out,
    output logic [7:0]         pending,
    output logic               overflow,
    output logic               clamped,
    output logic [31:0]        edge_count
);

    longint r_slot[$];      // scheduled target times, kept in ascending order
    longint r_fall_t;
    logic   r_fbclk_q;
    event   r_wake;

    assign code_ready = (pending < 8'(DEPTH));

    // Each scheduled time gets its own one-shot wake-up; stale wake-ups find nothing due.
    task automatic arm(input longint t);
        longint d;
        d = t - longint'($time);
        if (d > 0) begin
            fork
                begin
                    #(d);
                    -> r_wake;
                end
            join_none
        end
    endtask

    task automatic emit_due();
        longint now;
        longint t;
        now = longint'($time);
        if (dtc_out && r_fall_t <= now) begin
            dtc_out = 1'b0;
        end
        while (r_slot.size() > 0 && r_slot[0] <= now) begin
            t       = r_slot.pop_front();
            pending = pending - 8'd1;
            if (!dtc_out) begin
                dtc_out    = 1'b1;
                edge_count = edge_count + 32'd1;
            end
            // A rise landing inside a live pulse only stretches its fall.
            r_fall_t = t + PULSE_WIDTH;
            arm(r_fall_t);
        end
    endtask

    task automatic insert(input longint t);
        int idx;
        idx = r_slot.size();
        while (idx > 0 && r_slot[idx-1] > t) begin
            idx = idx - 1;
        end
        r_slot.insert(idx, t);
        pending = pending + 8'd1;
        arm(t);
    endtask

    task automatic accept();
        longint c;
        c       = longint'(code);
        clamped = 1'b0;
        if (code_valid) begin
            if (pending >= 8'(DEPTH)) begin
                overflow = 1'b1;
            end else if (c > TDC_RANGE || c < -TDC_RANGE) begin
`ifdef DTC_CLAMP_EN
                clamped = 1'b1;
                insert(longint'($time) + ((c > TDC_RANGE) ? 2 * TDC_RANGE : 64'sd0) * TDC_STEP);
`else
                $warning("dtc_edge_gen: out-of-range code %0d dropped", c);
`endif
            end else begin
                insert(longint'($time) + (c + TDC_RANGE) * TDC_STEP);
            end
        end
    endtask

    // NOTE: blocking assignments are deliberate here: this is an event-ordered model in which
    // an edge retired at a posedge must be visible to the accept decision in the same timestep.
    always begin
        @(fbclk or negedge resetn or r_wake);
        if (!resetn) begin
            r_slot.delete();
            r_fall_t   = 0;
            pending    = 8'd0;
            dtc_out    = 1'b0;
            overflow   = 1'b0;
            clamped    = 1'b0;
            edge_count = 32'd0;
        end else begin
            emit_due();
            if (fbclk && !r_fbclk_q) begin
                accept();
                emit_due();     // zero-delay codes fire in the accepting timestep
            end
        end
        r_fbclk_q = fbclk;
    end

endmodule

// File: tb/tb_dtc_edge_gen.sv
`timescale 1fs/1fs
// Self-checking bench for dtc_edge_gen: interval-based reference model compared on a fine time grid,
// plus directed scenarios with hand-computed edge times.
module tb_dtc_edge_gen;

    localparam longint STEP  = 1000;
    localparam longint RANGE = 4000;
    localparam longint PW    = 100000;
    localparam int     DEPTH = 4;
    localparam longint NS    = 1000000;

    logic               fbclk      = 1'b0;
    logic               resetn     = 1'b1;
    logic signed [31:0] code       = '0;
    logic               code_valid = 1'b0;
    logic               code_ready;
    logic               dtc_out;
    logic [7:0]         pending;
    logic               overflow;
    logic               clamped;
    logic [31:0]        edge_count;

    longint hp = 5 * NS;
    int     n_checks = 0;
    int     n_fail   = 0;

    // Model state: every target accepted since the last reset, plus sticky flags.
    longint m_tgt[$];
    logic   m_overflow = 1'b0;
    logic   m_clamped  = 1'b0;

    longint rise_q[$];
    longint fall_q[$];
    int     peak = 0;

    dtc_edge_gen #(
        .TDC_STEP   (STEP),
        .TDC_RANGE  (RANGE),
        .PULSE_WIDTH(PW),
        .DEPTH      (DEPTH)
    ) dut (
        .fbclk      (fbclk),
        .resetn     (resetn),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .dtc_out    (dtc_out),
        .pending    (pending),
        .overflow   (overflow),
        .clamped    (clamped),
        .edge_count (edge_count)
    );

    always #(hp) fbclk = ~fbclk;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t fs)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_pending(longint t);
        int n = 0;
        foreach (m_tgt[i]) if (m_tgt[i] > t) n++;
        return n;
    endfunction

    function automatic logic m_out(longint t);
        foreach (m_tgt[i]) if (m_tgt[i] <= t && t < m_tgt[i] + PW) return 1'b1;
        return 1'b0;
    endfunction

    // A target makes a new rising edge unless it lies strictly inside another pulse
    // or duplicates an earlier identical target.
    function automatic int m_edges(longint t);
        int   n = 0;
        logic covered;
        foreach (m_tgt[i]) begin
            if (m_tgt[i] <= t) begin
                covered = 1'b0;
                foreach (m_tgt[j]) begin
                    if (m_tgt[j] < m_tgt[i] && m_tgt[i] < m_tgt[j] + PW) covered = 1'b1;
                    if (j < i && m_tgt[j] == m_tgt[i]) covered = 1'b1;
                end
                if (!covered) n++;
            end
        end
        return n;
    endfunction

    always begin : model
        longint now;
        longint c;
        @(posedge fbclk or negedge resetn);
        if (!resetn) begin
            m_tgt.delete();
            m_overflow = 1'b0;
            m_clamped  = 1'b0;
        end else begin
            now       = longint'($time);
            c         = longint'(code);
            m_clamped = 1'b0;
            if (code_valid) begin
                if (m_pending(now) >= DEPTH) begin
                    m_overflow = 1'b1;
                end else if (c >= -RANGE && c <= RANGE) begin
                    m_tgt.push_back(now + (c + RANGE) * STEP);
                end else begin
`ifdef DTC_CLAMP_EN
                    m_clamped = 1'b1;
                    m_tgt.push_back(now + ((c > RANGE) ? RANGE : -RANGE) * STEP + RANGE * STEP);
`endif
                end
            end
        end
    end

    // Grid offset by 0.5 ps so no sample coincides with a clock, target or fall time.
    initial begin : compare
        longint t;
        #500;
        forever begin
            #10000;
            t = longint'($time);
            check("cmp_dtc_out",    dtc_out,    m_out(t));
            check("cmp_edge_count", edge_count, m_edges(t));
            check("cmp_pending",    pending,    m_pending(t));
            check("cmp_code_ready", code_ready, m_pending(t) < DEPTH);
            check("cmp_overflow",   overflow,   m_overflow);
            check("cmp_clamped",    clamped,    m_clamped);
        end
    end

    always begin
        @(posedge dtc_out);
        rise_q.push_back(longint'($time));
    end

    always begin
        @(negedge dtc_out);
        fall_q.push_back(longint'($time));
    end

    always begin
        @(pending);
        if (int'(pending) > peak) peak = int'(pending);
    end

    // ---------------- stimulus helpers ----------------
    function automatic longint rise_at(int i);
        return (rise_q.size() > i) ? rise_q[i] : -1;
    endfunction

    function automatic longint fall_at(int i);
        return (fall_q.size() > i) ? fall_q[i] : -1;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_dtc_out"},    dtc_out,    0);
        check({tag, "_pending"},    pending,    0);
        check({tag, "_code_ready"}, code_ready, 1);
        check({tag, "_overflow"},   overflow,   0);
        check({tag, "_clamped"},    clamped,    0);
        check({tag, "_edge_count"}, edge_count, 0);
    endtask

    task automatic do_reset(input longint new_hp);
        @(negedge fbclk);
        resetn     = 1'b0;
        code_valid = 1'b0;
        hp         = new_hp;
        #1000;
        check_reset_values("rst");
        @(negedge fbclk);
        @(negedge fbclk);
        resetn = 1'b1;
        rise_q.delete();
        fall_q.delete();
        peak = 0;
    endtask

    task automatic send(input int c, output longint t_acc);
        @(negedge fbclk);
        code       = c;
        code_valid = 1'b1;
        @(posedge fbclk);
        t_acc = longint'($time);
    endtask

    task automatic idle();
        @(negedge fbclk);
        code_valid = 1'b0;
        code       = '0;
    endtask

    task automatic wait_ns(input longint n);
        #(n * NS);
    endtask

    int lb_code[4] = '{-1000, 0, 1500, -4000};

    initial begin : main
        longint t0, t1, tx;
        #100;
        resetn = 1'b0;

        // Basic edge: code 0 -> rise 4 ns later, 100 ps wide.
        do_reset(5 * NS);
        send(0, t0);
        idle();
        wait_ns(20);
        check("basic_rises",      rise_q.size(), 1);
        check("basic_delay",      rise_at(0) - t0, 4 * NS);
        check("basic_high_time",  fall_at(0) - rise_at(0), PW);
        check("basic_edge_count", edge_count, 1);
        check("basic_pending",    pending, 0);

        // Loopback: a TDC referenced to the accepting posedge reads -code.
        foreach (lb_code[i]) begin
            rise_q.delete();
            send(lb_code[i], t0);
            idle();
            wait_ns(20);
            check("loopback_tdc", (rise_q.size() == 1) ? RANGE - (rise_at(0) - t0) / STEP : 99999,
                  -lb_code[i]);
        end
        check("loopback_edge_count", edge_count, 5);

        // Reordering: later code with a shorter delay emits first.
        do_reset(1 * NS);
        send(3000, t0);
        send(-3000, t1);
        idle();
        wait_ns(20);
        check("reorder_rises",  rise_q.size(), 2);
        check("reorder_first",  rise_at(0) - t0, 3 * NS);
        check("reorder_second", rise_at(1) - t0, 7 * NS);
        check("reorder_peak",   peak, 2);

        // Overflow: five +4000 codes at 1 ns period; the fifth is dropped.
        do_reset(NS / 2);
        for (int k = 0; k < 4; k++) send(4000, tx);
        #1000;
        check("ovf_ready_low", code_ready, 0);
        check("ovf_pending4",  pending, 4);
        send(4000, tx);
        #1000;
        check("ovf_flag",      overflow, 1);
        check("ovf_pending",   pending, 4);
        idle();
        wait_ns(20);
        check("ovf_rises",     rise_q.size(), 4);
        check("ovf_edges",     edge_count, 4);
        check("ovf_sticky",    overflow, 1);

        // Full table still accepts when an edge retires on the same posedge.
        do_reset(NS / 2);
        send(0, t0);
        for (int k = 0; k < 3; k++) send(4000, tx);
        send(4000, t1);
        #1000;
        check("retire_accept_ovf",     overflow, 0);
        check("retire_accept_pending", pending, 4);
        idle();
        wait_ns(20);
        check("retire_accept_edges",   edge_count, 5);

        // Merge: second target lands inside the first pulse.
        do_reset(NS / 2);
        send(0, t0);
        send(-1050, t1);
        idle();
        wait_ns(10);
        check("merge_rises", rise_q.size(), 1);
        check("merge_rise",  rise_at(0) - t0, 3950000);
        check("merge_fall",  fall_at(0) - t0, 4100000);
        check("merge_edges", edge_count, 1);

        // Identical targets: one rise, both retired.
        do_reset(NS / 2);
        send(0, t0);
        send(-1000, t1);
        #1000;
        check("same_t_pending2", pending, 2);
        idle();
        wait_ns(10);
        check("same_t_rises",   rise_q.size(), 1);
        check("same_t_rise",    rise_at(0) - t0, 4 * NS);
        check("same_t_edges",   edge_count, 1);
        check("same_t_pending", pending, 0);

        // Out-of-range code.
        do_reset(5 * NS);
        send(5000, t0);
        #1000;
`ifdef DTC_CLAMP_EN
        check("clamp_flag",    clamped, 1);
        check("clamp_pending", pending, 1);
        idle();
        wait_ns(20);
        check("clamp_rises",   rise_q.size(), 1);
        check("clamp_rise",    rise_at(0) - t0, 8 * NS);
        check("clamp_edges",   edge_count, 1);
`else
        check("drop_flag",     clamped, 0);
        check("drop_pending",  pending, 0);
        idle();
        wait_ns(20);
        check("drop_rises",    rise_q.size(), 0);
        check("drop_edges",    edge_count, 0);
`endif

        // Reset mid-operation cancels the scheduled +8 ns edge.
        do_reset(5 * NS);
        send(4000, t0);
        #1000;
        code_valid = 1'b0;
        #(3 * NS - 1000);
        resetn = 1'b0;
        #1000;
        check_reset_values("midrst");
        #(2 * NS - 1000);
        resetn = 1'b1;
        wait_ns(20);
        check("midrst_no_rise", rise_q.size(), 0);
        check("midrst_edges",   edge_count, 0);
        send(0, t1);
        idle();
        wait_ns(20);
        check("midrst_new_rise",  rise_at(0) - t1, 4 * NS);
        check("midrst_new_edges", edge_count, 1);

        // Reset while dtc_out is high drops it in the same timestep.
        do_reset(5 * NS);
        send(0, t0);
        #1000;
        code_valid = 1'b0;
        #(4 * NS + 50000 - 1000);
        check("rsthigh_before", dtc_out, 1);
        resetn = 1'b0;
        #1;
        check("rsthigh_drop", dtc_out, 0);
        #(1 * NS);
        resetn = 1'b1;
        wait_ns(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
